// File: rtl/arb_req_pkg.sv
// Shared types and defaults for the arbiter requester agent.
package arb_req_pkg;

  localparam int unsigned DEF_LEN_W   = 4;
  localparam int unsigned DEF_TIMEOUT = 16;
  localparam int unsigned DEF_CNT_W   = 8;

  // Legacy state encodings, kept so existing decoders of the state bits still match.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_WAIT = ST_WAIT,
    S_XFER = ST_XFER
  } state_e;

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] lim;
    lim = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= lim) ? lim : v + 32'd1;
  endfunction

endpackage

// File: rtl/arb_req_wdog.sv
// Grant-starvation watchdog: counts consecutive stalled cycles and flags
// expiry on the TIMEOUT-th one.
module arb_req_wdog #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic stall,
  output logic expire
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt;

  assign expire = stall && (cnt == CW'(TIMEOUT - 1));

  // Stall counter; expiry restarts it since the owner returns to idle.
  always_ff @(posedge clk) begin
    if (rst || clear || expire) begin
      cnt <= '0;
    end else if (stall) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/arb_requester.sv
// Client-side agent for one lane of the fixed-priority 4-way arbiter.
// Accepts an N-beat job, holds req until N granted beats are taken,
// survives preemption and aborts on grant starvation.
// Optional: define ARB_REQUESTER_STATS_EN to add preempt_cnt / wait_max.
module arb_requester
  import arb_req_pkg::*;
#(
  parameter int unsigned LEN_W   = DEF_LEN_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
`ifdef ARB_REQUESTER_STATS_EN
  ,
  parameter int unsigned CNT_W   = DEF_CNT_W
`endif
) (
  input  logic             c,
  input  logic             r,
  input  logic             job_valid,
  input  logic [LEN_W-1:0] job_len,
  output logic             job_ready,
  output logic             req,
  input  logic             gnt,
  output logic             beat,
  output logic             done,
  output logic             abort,
  output logic             busy
`ifdef ARB_REQUESTER_STATS_EN
  ,
  output logic [CNT_W-1:0] preempt_cnt,
  output logic [CNT_W-1:0] wait_max
`endif
);

  state_e           state;
  logic             req_q;
  logic             done_q;
  logic             abort_q;
  logic [LEN_W-1:0] remaining;
  logic             active;
  logic             accept;
  logic             beat_int;
  logic             stall;
  logic             expire;

  assign active   = (state != S_IDLE);
  assign accept   = (state == S_IDLE) && job_valid;
  // A registered grant trailing a dropped req lands in IDLE and is ignored.
  assign beat_int = gnt && req_q && active;
  assign stall    = active && !gnt;

  // Outputs are forced quiet while reset is held, before the registers clear.
  assign job_ready = (state == S_IDLE) || r;
  assign req       = req_q && !r;
  assign beat      = beat_int && !r;
  assign done      = done_q && !r;
  assign abort     = abort_q && !r;
  assign busy      = active && !r;

  arb_req_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk   (c),
    .rst   (r),
    .clear (accept || beat_int),
    .stall (stall),
    .expire(expire)
  );

  // Job FSM: accept, count granted beats, finish or abort.
  always_ff @(posedge c) begin
    if (r) begin
      state     <= S_IDLE;
      req_q     <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      remaining <= '0;
    end else begin
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (job_valid) begin
            remaining <= (job_len == '0) ? LEN_W'(1) : job_len;
            req_q     <= 1'b1;
            state     <= S_WAIT;
          end
        end
        S_WAIT, S_XFER: begin
          // A beat takes precedence over expiry; expire needs gnt=0 anyway.
          if (beat_int) begin
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              req_q  <= 1'b0;
              done_q <= 1'b1;
              state  <= S_IDLE;
            end else begin
              state <= S_XFER;
            end
          end else if (expire) begin
            req_q     <= 1'b0;
            abort_q   <= 1'b1;
            remaining <= '0;
            state     <= S_IDLE;
          end
        end
        default: begin
          req_q <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ARB_REQUESTER_STATS_EN
  logic             gnt_q;
  logic [CNT_W-1:0] preempt_q;
  logic [CNT_W-1:0] wait_q;
  logic [CNT_W-1:0] wait_cnt;

  // Count grant losses during a burst and track worst accept-to-first-beat latency.
  always_ff @(posedge c) begin
    if (r) begin
      gnt_q     <= 1'b0;
      preempt_q <= '0;
      wait_q    <= '0;
      wait_cnt  <= '0;
    end else begin
      gnt_q <= gnt;
      if ((state == S_XFER) && gnt_q && !gnt) begin
        preempt_q <= CNT_W'(sat_inc(32'(preempt_q), CNT_W));
      end
      if (accept) begin
        wait_cnt <= CNT_W'(1);
      end else if (state == S_WAIT) begin
        if (beat_int) begin
          if (wait_cnt > wait_q) begin
            wait_q <= wait_cnt;
          end
        end else begin
          wait_cnt <= CNT_W'(sat_inc(32'(wait_cnt), CNT_W));
        end
      end
    end
  end

  assign preempt_cnt = r ? '0 : preempt_q;
  assign wait_max    = r ? '0 : wait_q;
`endif

endmodule

// File: tb/tb_arb_requester.sv
// Self-checking bench for arb_requester (TIMEOUT overridden to 8).
// Checks stats outputs as well when ARB_REQUESTER_STATS_EN is defined.
module tb_arb_requester;

  localparam int unsigned TMO = 8;

  logic       c = 1'b0;
  logic       r;
  logic       job_valid;
  logic [3:0] job_len;
  logic       job_ready;
  logic       req;
  logic       gnt;
  logic       beat;
  logic       done;
  logic       abort;
  logic       busy;
`ifdef ARB_REQUESTER_STATS_EN
  logic [7:0] preempt_cnt;
  logic [7:0] wait_max;
  int         m_preempt;
  int         m_wait_max;
`endif

  int errors = 0;
  int checks = 0;

  bit gpat[256];
  int glen;

  arb_requester #(
    .LEN_W  (4),
    .TIMEOUT(TMO)
  ) dut (
    .c        (c),
    .r        (r),
    .job_valid(job_valid),
    .job_len  (job_len),
    .job_ready(job_ready),
    .req      (req),
    .gnt      (gnt),
    .beat     (beat),
    .done     (done),
    .abort    (abort),
    .busy     (busy)
`ifdef ARB_REQUESTER_STATS_EN
    ,
    .preempt_cnt(preempt_cnt),
    .wait_max   (wait_max)
`endif
  );

  always #5 c = ~c;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Runs one job against the grant pattern in gpat[0..glen-1] (0 beyond it).
  // Expected behaviour derived per cycle from the job rules: a granted cycle
  // is a beat, N beats finish the job, TMO consecutive ungranted cycles abort it.
  task automatic run_job(input string name, input int len, input bit stale_g);
    int n, beats, stall, t, end_t, first_t, pc;
    bit dn, g, pg;
    bit eb[256];
    n = (len == 0) ? 1 : len;
    beats = 0; stall = 0; t = 0; dn = 0; first_t = 0; pc = 0; pg = 0;
    while (t < 250) begin
      g = (t < glen) ? gpat[t] : 1'b0;
      eb[t] = g;
      t++;
      if (g) begin
        if (first_t == 0) first_t = t;
        beats++;
        stall = 0;
        if (beats == n) begin
          dn = 1;
          break;
        end
      end else begin
        if (beats > 0 && pg) pc++;
        stall++;
        if (stall == TMO) break;
      end
      pg = g;
    end
    end_t = t;

    // accept cycle
    r = 0; job_valid = 1; job_len = 4'(len); gnt = 1'($urandom_range(0, 1));
    @(negedge c);
    checks++;
    if ({job_ready, req, busy, beat} !== 4'b1000) begin
      errors++;
      $display("FAIL %s accept: ready,req,busy,beat=%b expected 1000", name, {job_ready, req, busy, beat});
    end
    @(posedge c); #1;

    for (int i = 0; i < end_t; i++) begin
      job_valid = 1'($urandom_range(0, 1));
      job_len   = 4'($urandom);
      gnt       = eb[i];
      @(negedge c);
      checks++;
      if ({req, beat, busy, job_ready, done, abort} !== {1'b1, eb[i], 1'b1, 1'b0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL %s cycle%0d: req,beat,busy,ready,done,abort=%b expected %b", name, i + 1,
                 {req, beat, busy, job_ready, done, abort}, {1'b1, eb[i], 1'b1, 1'b0, 1'b0, 1'b0});
      end
      @(posedge c); #1;
    end

    // completion cycle: stale grant must not produce a beat
    job_valid = 0; gnt = stale_g;
    @(negedge c);
    checks++;
    if ({req, beat, busy, job_ready, done, abort} !== {1'b0, 1'b0, 1'b0, 1'b1, dn, !dn}) begin
      errors++;
      $display("FAIL %s end: req,beat,busy,ready,done,abort=%b expected %b", name,
               {req, beat, busy, job_ready, done, abort}, {1'b0, 1'b0, 1'b0, 1'b1, dn, !dn});
    end
`ifdef ARB_REQUESTER_STATS_EN
    m_preempt += pc;
    if (first_t > m_wait_max) m_wait_max = first_t;
    checks++;
    if ({preempt_cnt, wait_max} !== {8'(m_preempt), 8'(m_wait_max)}) begin
      errors++;
      $display("FAIL %s stats: preempt=%0d wait_max=%0d expected %0d %0d", name,
               preempt_cnt, wait_max, m_preempt, m_wait_max);
    end
`endif
    @(posedge c); #1;

    gnt = 0;
    @(negedge c);
    checks++;
    if ({req, busy, done, abort} !== 4'b0000) begin
      errors++;
      $display("FAIL %s settle: req,busy,done,abort=%b expected 0000", name, {req, busy, done, abort});
    end
    @(posedge c); #1;
  endtask

  task automatic test_reset();
    r = 1; job_valid = 1; job_len = 4'd3; gnt = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge c);
      checks++;
      if ({job_ready, req, beat, done, abort, busy} !== 6'b100000) begin
        errors++;
        $display("FAIL reset%0d: ready,req,beat,done,abort,busy=%b expected 100000", i,
                 {job_ready, req, beat, done, abort, busy});
      end
      @(posedge c); #1;
    end
    r = 0; job_valid = 0; gnt = 0;
`ifdef ARB_REQUESTER_STATS_EN
    m_preempt = 0; m_wait_max = 0;
`endif
  endtask

  task automatic test_solo();
    gpat[0] = 0; gpat[1] = 1; gpat[2] = 1; gpat[3] = 1; glen = 4;
    run_job("solo", 3, 1'b1);
  endtask

  task automatic test_len0();
    gpat[0] = 0; gpat[1] = 1; glen = 2;
    run_job("len0", 0, 1'b0);
  endtask

  task automatic test_preempt();
    gpat[0] = 1; gpat[1] = 1; gpat[2] = 0; gpat[3] = 0; gpat[4] = 1; gpat[5] = 1; glen = 6;
    run_job("preempt", 4, 1'b0);
  endtask

  task automatic test_starve();
    glen = 0;
    run_job("starve", 5, 1'b0);
  endtask

  task automatic test_stale();
    gpat[0] = 1; gpat[1] = 1; glen = 2;
    run_job("stale", 2, 1'b1);
  endtask

  task automatic test_random();
    int prob;
    for (int j = 0; j < 20; j++) begin
      case ($urandom_range(0, 2))
        0:       prob = 12;
        1:       prob = 50;
        default: prob = 90;
      endcase
      for (int k = 0; k < 256; k++) gpat[k] = ($urandom_range(0, 99) < prob);
      glen = 256;
      run_job("random", int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid();
    r = 0; job_valid = 1; job_len = 4'd5; gnt = 0;
    @(posedge c); #1;
    job_valid = 0;
    for (int i = 0; i < 2; i++) begin
      gnt = 1;
      @(negedge c);
      checks++;
      if ({req, beat} !== 2'b11) begin
        errors++;
        $display("FAIL reset_mid beat%0d: req,beat=%b expected 11", i, {req, beat});
      end
      @(posedge c); #1;
    end
    r = 1; gnt = 1;
    @(negedge c);
    checks++;
    if ({job_ready, req, beat, busy, done, abort} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_mid held: ready,req,beat,busy,done,abort=%b expected 100000",
               {job_ready, req, beat, busy, done, abort});
    end
    @(posedge c); #1;
    r = 0; gnt = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge c);
      checks++;
      if ({job_ready, req, busy, done, abort} !== 5'b10000) begin
        errors++;
        $display("FAIL reset_mid after%0d: ready,req,busy,done,abort=%b expected 10000", i,
                 {job_ready, req, busy, done, abort});
      end
`ifdef ARB_REQUESTER_STATS_EN
      checks++;
      if ({preempt_cnt, wait_max} !== 16'h0000) begin
        errors++;
        $display("FAIL reset_mid stats: preempt=%0d wait_max=%0d expected 0 0", preempt_cnt, wait_max);
      end
`endif
      @(posedge c); #1;
    end
  endtask

  initial begin
    r = 1; job_valid = 0; job_len = '0; gnt = 0;
    test_reset();
    test_solo();
    test_len0();
    test_preempt();
    test_starve();
    test_stale();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
